load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits directly upstream of the data-memory block (13-bit byte addr, word dout, funct3/write
//  inputs, one-cycle synchronous read). Accepts core load/store requests via a valid/ready
//  handshake, checks alignment/range/funct3, and issues only full-word memory accesses.
//  SB/SH become read-modify-write; loads return a lane-extracted, sign/zero-extended word.
// PARAMETERS
//  ADDR_W        13        memory byte-address width (8 KiB)
//  BASE_ADDR     32'h0     base of the data window; valid: BASE_ADDR <= addr < BASE_ADDR+2**ADDR_W
//  READ_LATENCY  1         cycles from mem_addr stable to mem_dout valid (1..3)
// PORTS
//  clk          in   1       single clock
//  reset        in   1       synchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       high only in IDLE; transfer when req_valid && req_ready
//  req_write    in   1       1 = store, 0 = load
//  req_funct3   in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr     in   32      byte address
//  req_wdata    in   32      store data, right-justified
//  resp_valid   out  1       one-cycle completion pulse, no backpressure
//  resp_rdata   out  32      load result (0 for stores and errors)
//  resp_err     out  1       misaligned / out-of-range / illegal funct3, valid with resp_valid
//  mem_write    out  1       write strobe to memory
//  mem_funct3   out  3       constant 3'b010 (word)
//  mem_addr     out  ADDR_W  word-aligned address, held stable for the whole access
//  mem_din      out  32      full word to write
//  mem_dout     in   32      word read from memory
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; req_ready, resp_valid, resp_err, mem_write=0;
//    resp_rdata, mem_addr, mem_din=0. Reset mid-access aborts it; no write issued after reset.
//  - States: IDLE, RD_WAIT, WRITE, RESP. All outputs registered.
//  - IDLE: req_ready=1. On transfer latch write/funct3/offset=addr[1:0]/wdata; mem_addr <=
//    {off[ADDR_W-1:2],2'b00}, off=req_addr-BASE_ADDR.
//    * Error -> RESP with err=1, no memory access. Error = out of range; funct3 illegal
//      (load 011/110/111, store >=011); LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0.
//    * SW -> WRITE. Loads, SB, SH -> RD_WAIT.
//  - RD_WAIT: counter 0..READ_LATENCY-1; on last cycle capture mem_dout.
//    Load -> RESP with extracted data; SB/SH -> WRITE with merged word.
//  - Load extract: LB/LBU byte at offset*8, LH/LHU half at offset[1]*16, sign (LB/LH) or
//    zero (LBU/LHU) extend to 32; LW whole word.
//  - Store merge: replace only the addressed byte/half of the captured word; other lanes kept.
//  - WRITE: mem_write=1 exactly one cycle, mem_din=final word -> RESP.
//  - RESP: resp_valid=1 one cycle, req_ready=0 -> IDLE. Back-to-back requests accepted one
//    cycle later.
//  - Latency, acceptance cycle=0, READ_LATENCY=1: error resp cycle 1; SW write cycle 1,
//    resp 2; load resp 2; SB/SH write 2, resp 3. Each extra latency cycle adds 1 to read
//    paths.
//  - mem_addr changes only in IDLE on acceptance (memory bank selection is address-derived).
//  - req_* ignored outside IDLE. resp_rdata held until next RESP.
// STRUCTURE
//  - Shared header lsu_defs.vh: funct3 constants (F3_B/H/W/BU/HU), state encodings,
//    MEM_F3_WORD=3'b010.
//  - Sub-module lsu_align (combinational): load extract/extend and store lane merge,
//    driven by funct3, offset, word, wdata.
//  - Top: FSM, latency counter, request/response registers.
// TESTING
//  1. SW 0xDEADBEEF @0x10 -> mem_write one pulse, mem_addr=0x10, mem_din=0xDEADBEEF; resp cycle 2, err=0.
//  2. LB/LBU @0x13 with word 0x80FF7F01 -> LB 0xFFFFFF80, LBU 0x00000080; LH @0x12 -> 0xFFFF80FF.
//  3. SB 0xAA @0x11 on 0x11223344 -> one read, write 0x1122AA44 at cycle 2, resp cycle 3.
//  4. LW @0x2 / SH @0x1 / LW @0x2000 / funct3=3'b011 load -> resp_err=1 at cycle 1, mem_write never.
//  5. reset low during SB RD_WAIT -> no mem_write, req_ready=0 during reset, 1 after release.
//  6. READ_LATENCY=3 LW -> resp cycle 4; back-to-back LW stream: req_ready only in IDLE, 1 resp/request.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and request-legality helpers.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B        = 3'b000;
    localparam logic [2:0] F3_H        = 3'b001;
    localparam logic [2:0] F3_W        = 3'b010;
    localparam logic [2:0] F3_BU       = 3'b100;
    localparam logic [2:0] F3_HU       = 3'b101;
    localparam logic [2:0] MEM_F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Stores only have byte/half/word; loads add the unsigned byte/half forms.
    function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
        logic bad;
        if (write)
            bad = (f3 > F3_W);
        else
            bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering between a memory word and the core: load extract/extend and
// store read-modify-write merge.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic signed [31:0] ext_b;
    logic signed [31:0] ext_h;

    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = word[{offset[1], 4'b0000} +: 16];
        ext_b  = 32'(lane_b);
        ext_h  = 32'(lane_h);

        load_data = word;
        case (funct3)
            F3_B:    load_data = ext_b;
            F3_H:    load_data = ext_h;
            F3_BU:   load_data = {24'b0, lane_b};
            F3_HU:   load_data = {16'b0, lane_h};
            default: load_data = word;
        endcase

        // Only the addressed lane takes new data; the rest of the captured word survives.
        store_word = wdata;
        case (funct3[1:0])
            2'b00: begin
                store_word = word;
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                store_word = word;
                store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide synchronous data memory; sub-word
// stores are done as read-modify-write, all memory accesses are full words.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          ADDR_W       = 13,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          READ_LATENCY = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam logic [31:0] WINDOW   = 32'(1) << ADDR_W;
    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);

    state_t      state, state_next;
    logic        op_write;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic [31:0] op_wdata;
    logic [1:0]  lat_cnt;
    logic [31:0] off_full;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        accept;
    logic        req_err;
    logic        lat_done;

    assign off_full   = req_addr - BASE_ADDR;
    assign accept     = req_valid && req_ready;
    assign req_err    = (req_addr < BASE_ADDR) || (off_full >= WINDOW) ||
                        f3_illegal(req_write, req_funct3) ||
                        misaligned(req_funct3, req_addr[1:0]);
    assign lat_done   = (lat_cnt == LAT_LAST);
    assign mem_funct3 = MEM_F3_WORD;

    load_store_unit_align u_align (
        .funct3     (op_f3),
        .offset     (op_off),
        .word       (mem_dout),
        .wdata      (op_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (req_write && req_funct3 == F3_W)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (lat_done)
                    state_next = op_write ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Every output is a flop: strobes are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_write  <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            lat_cnt    <= '0;
            op_write   <= 1'b0;
            op_f3      <= '0;
            op_off     <= '0;
            op_wdata   <= '0;
        end else begin
            state      <= state_next;
            req_ready  <= (state_next == ST_IDLE);
            resp_valid <= (state_next == ST_RESP);
            mem_write  <= (state_next == ST_WRITE);
            resp_err   <= (state == ST_IDLE) && accept && req_err;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_write <= req_write;
                        op_f3    <= req_funct3;
                        op_off   <= req_addr[1:0];
                        op_wdata <= req_wdata;
                        lat_cnt  <= '0;
                        mem_addr <= {off_full[ADDR_W-1:2], 2'b00};
                        if (req_write)
                            mem_din <= req_wdata;
                        if (req_err)
                            resp_rdata <= '0;
                    end
                end
                ST_RD_WAIT: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_done) begin
                        if (op_write)
                            mem_din <= store_word;
                        else
                            resp_rdata <= load_data;
                    end
                end
                ST_WRITE: resp_rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule
